// File: rtl/exec_arith_pkg.sv
// Shared definitions for the execute-stage arithmetic unit: ALU opcodes, datapath width
// and the divide-by-zero quotient.
package exec_arith_pkg;

    localparam int DATA_W = 32;

    localparam logic [DATA_W-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;
    localparam logic [DATA_W-1:0] INT_MIN           = 32'h8000_0000;
    localparam logic [DATA_W-1:0] MINUS_ONE         = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_XOR  = 4'b0011,
        ALU_NOR  = 4'b0100,
        ALU_SLTU = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_SRL  = 4'b1001,
        ALU_SRA  = 4'b1010,
        ALU_SLLV = 4'b1011,
        ALU_SRLV = 4'b1100,
        ALU_SRAV = 4'b1101,
        ALU_LUI  = 4'b1110,
        ALU_ZERO = 4'b1111
    } alu_op_e;

    // Two's-complement magnitude; INT_MIN maps to itself, which is correct as an unsigned value.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/exec_divider.sv
// Single-cycle combinational signed divider: truncating quotient, remainder signed like the
// dividend, with explicit divide-by-zero and INT_MIN / -1 results.
module exec_divider
    import exec_arith_pkg::*;
(
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W-1:0] quo_mag;
    logic [DATA_W:0]   rem_acc;
    logic              quo_neg;
    logic              rem_neg;
    logic              unused_rem_msb;

    assign a_mag   = magnitude(dividend);
    assign b_mag   = magnitude(divisor);
    assign quo_neg = dividend[DATA_W-1] ^ divisor[DATA_W-1];
    assign rem_neg = dividend[DATA_W-1];

    // Unrolled restoring division on magnitudes; the partial remainder stays below b_mag,
    // so its top bit is only needed during the compare.
    always_comb begin
        // NOTE: blocking assignments here model the ripple through the unrolled stages;
        // defaulting every output first keeps this block free of inferred latches.
        rem_acc = '0;
        quo_mag = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            rem_acc = {rem_acc[DATA_W-1:0], a_mag[i]};
            if (rem_acc >= {1'b0, b_mag}) begin
                rem_acc    = rem_acc - {1'b0, b_mag};
                quo_mag[i] = 1'b1;
            end
        end
    end

    assign unused_rem_msb = rem_acc[DATA_W];

    always_comb begin
        quotient  = quo_neg ? (~quo_mag + 1'b1) : quo_mag;
        remainder = rem_neg ? (~rem_acc[DATA_W-1:0] + 1'b1) : rem_acc[DATA_W-1:0];
        if (divisor == '0) begin
            quotient  = DIV_ZERO_QUOTIENT;
            remainder = dividend;
        end else if (dividend == INT_MIN && divisor == MINUS_ONE) begin
            quotient  = INT_MIN;
            remainder = '0;
        end
    end

endmodule

// File: rtl/exec_arith_unit.sv
// Execute-stage arithmetic: combinational ALU/shifter, address adder, and HI/LO loaded by the
// divider (and by a signed multiplier when EXEC_MULT_EN is defined).
module exec_arith_unit
    import exec_arith_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic [3:0]  alucontrol,
    input  logic [4:0]  shamt,
    input  logic [31:0] add_a,
    input  logic [31:0] add_b,
    input  logic        div_en,
    input  logic        mult_en,
    output logic [31:0] aluout,
    output logic [31:0] add_y,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [DATA_W-1:0] hi_d, hi_q;
    logic [DATA_W-1:0] lo_d, lo_q;
    logic [DATA_W-1:0] div_quotient;
    logic [DATA_W-1:0] div_remainder;
    logic [4:0]        var_shamt;

    assign var_shamt = srca[4:0];
    assign add_y     = add_a + add_b;

    always_comb begin
        aluout = '0;
        case (alu_op_e'(alucontrol))
            ALU_AND:  aluout = srca & srcb;
            ALU_OR:   aluout = srca | srcb;
            ALU_ADD:  aluout = srca + srcb;
            ALU_XOR:  aluout = srca ^ srcb;
            ALU_NOR:  aluout = ~(srca | srcb);
            ALU_SLTU: aluout = {31'b0, (srca < srcb)};
            ALU_SUB:  aluout = srca - srcb;
            ALU_SLT:  aluout = {31'b0, ($signed(srca) < $signed(srcb))};
            ALU_SLL:  aluout = srcb << shamt;
            ALU_SRL:  aluout = srcb >> shamt;
            ALU_SRA:  aluout = $unsigned($signed(srcb) >>> shamt);
            ALU_SLLV: aluout = srcb << var_shamt;
            ALU_SRLV: aluout = srcb >> var_shamt;
            ALU_SRAV: aluout = $unsigned($signed(srcb) >>> var_shamt);
            ALU_LUI:  aluout = {srcb[15:0], 16'b0};
            ALU_ZERO: aluout = '0;
            default:  aluout = '0;
        endcase
    end

    exec_divider u_divider (
        .dividend  (srca),
        .divisor   (srcb),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

`ifdef EXEC_MULT_EN
    logic [2*DATA_W-1:0] product;

    assign product = $unsigned($signed(srca) * $signed(srcb));

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_en) begin
            hi_d = div_remainder;
            lo_d = div_quotient;
        end else if (mult_en) begin
            hi_d = product[2*DATA_W-1:DATA_W];
            lo_d = product[DATA_W-1:0];
        end
    end
`else
    logic unused_mult_en;

    assign unused_mult_en = mult_en;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_en) begin
            hi_d = div_remainder;
            lo_d = div_quotient;
        end
    end
`endif

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_exec_arith_unit.sv
// Directed self-checking bench for exec_arith_unit: table-driven ALU/adder vectors plus
// hand-written HI/LO sequences (multiplier expectations follow EXEC_MULT_EN).
module tb_exec_arith_unit;

    logic        clk;
    logic        reset;
    logic [31:0] srca, srcb, add_a, add_b;
    logic [3:0]  alucontrol;
    logic [4:0]  shamt;
    logic        div_en, mult_en;
    logic [31:0] aluout, add_y, hi, lo;

    int checks   = 0;
    int failures = 0;

    exec_arith_unit dut (
        .clk        (clk),
        .reset      (reset),
        .srca       (srca),
        .srcb       (srcb),
        .alucontrol (alucontrol),
        .shamt      (shamt),
        .add_a      (add_a),
        .add_b      (add_b),
        .div_en     (div_en),
        .mult_en    (mult_en),
        .aluout     (aluout),
        .add_y      (add_y),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [4:0]  sh;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } alu_vec_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } add_vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Drive operands and enables, take one rising edge, sample 1 time unit later.
    task automatic clock_op(input logic [31:0] a, input logic [31:0] b,
                            input logic de, input logic me, input logic rst);
        srca    = a;
        srcb    = b;
        div_en  = de;
        mult_en = me;
        reset   = rst;
        @(posedge clk);
        #1;
        div_en  = 1'b0;
        mult_en = 1'b0;
        reset   = 1'b0;
    endtask

    task automatic check_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        check({name, ".hi"}, hi, exp_hi);
        check({name, ".lo"}, lo, exp_lo);
    endtask

    alu_vec_t alu_vecs[$];
    add_vec_t add_vecs[$];

    initial begin
        alu_vecs = '{
            '{"and",   4'b0000, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0005},
            '{"or",    4'b0001, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFFD},
            '{"add",   4'b0010, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002},
            '{"xor",   4'b0011, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFF_FFF8},
            '{"nor",   4'b0100, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0002},
            '{"sltu",  4'b0101, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0001},
            '{"sub",   4'b0110, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0008},
            '{"slt",   4'b0111, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'h0000_0000},
            '{"slt_n", 4'b0111, 5'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0001},
            '{"sltu_0",4'b0101, 5'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'h0000_0000},
            '{"sub_w", 4'b0110, 5'd0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF},
            '{"sll",   4'b1000, 5'd4, 32'h0000_0000, 32'h8000_0010, 32'h0000_0100},
            '{"srl",   4'b1001, 5'd4, 32'h0000_0000, 32'h8000_0010, 32'h0800_0001},
            '{"sra",   4'b1010, 5'd4, 32'h0000_0000, 32'h8000_0010, 32'hF800_0001},
            '{"sllv",  4'b1011, 5'd0, 32'h0000_0024, 32'h8000_0010, 32'h0000_0100},
            '{"srlv",  4'b1100, 5'd0, 32'h0000_0024, 32'h8000_0010, 32'h0800_0001},
            '{"srav",  4'b1101, 5'd0, 32'h0000_0024, 32'h8000_0010, 32'hF800_0001},
            '{"sra_p", 4'b1010, 5'd31,32'h0000_0000, 32'h7FFF_FFFF, 32'h0000_0000},
            '{"lui",   4'b1110, 5'd0, 32'h0000_0005, 32'hFFFF_FFFD, 32'hFFFD_0000},
            '{"zero",  4'b1111, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000}
        };
        add_vecs = '{
            '{"add_wrap", 32'hFFFF_FFFC, 32'h0000_0004, 32'h0000_0000},
            '{"add_pc",   32'h0040_0000, 32'h0000_0010, 32'h0040_0010},
            '{"add_neg",  32'h0000_0010, 32'hFFFF_FFF0, 32'h0000_0000}
        };

        srca = '0; srcb = '0; add_a = '0; add_b = '0;
        alucontrol = '0; shamt = '0;
        div_en = 1'b0; mult_en = 1'b0; reset = 1'b1;

        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_hilo("reset", 32'h0, 32'h0);

        foreach (alu_vecs[i]) begin
            alucontrol = alu_vecs[i].op;
            shamt      = alu_vecs[i].sh;
            srca       = alu_vecs[i].a;
            srcb       = alu_vecs[i].b;
            #1;
            check({"alu_", alu_vecs[i].name}, aluout, alu_vecs[i].exp);
        end

        foreach (add_vecs[i]) begin
            add_a = add_vecs[i].a;
            add_b = add_vecs[i].b;
            #1;
            check(add_vecs[i].name, add_y, add_vecs[i].exp);
        end

        // Combinational outputs keep following inputs while reset is asserted.
        reset      = 1'b1;
        alucontrol = 4'b0010;
        srca       = 32'h0000_0003;
        srcb       = 32'h0000_0004;
        add_a      = 32'h0000_0100;
        add_b      = 32'h0000_0001;
        #1;
        check("alu_in_reset", aluout, 32'h0000_0007);
        check("add_in_reset", add_y, 32'h0000_0101);
        reset = 1'b0;

        clock_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        check_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        clock_op(32'h1234_5678, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        clock_op(32'h0000_0064, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
        check_hilo("div_hold", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        clock_op(32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        check_hilo("div_7_m2", 32'h0000_0001, 32'hFFFF_FFFD);
        clock_op(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
        check_hilo("div_m7_m2", 32'hFFFF_FFFF, 32'h0000_0003);
        clock_op(32'h0000_0064, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        check_hilo("div_100_7", 32'h0000_0002, 32'h0000_000E);
        clock_op(32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        check_hilo("div_by_zero", 32'h1234_5678, 32'hFFFF_FFFF);
        clock_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        check_hilo("div_ovf", 32'h0000_0000, 32'h8000_0000);
        clock_op(32'h8000_0000, 32'h0000_0002, 1'b1, 1'b0, 1'b0);
        check_hilo("div_min_2", 32'h0000_0000, 32'hC000_0000);

        clock_op(32'h0000_0064, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        clock_op(32'h0000_0064, 32'h0000_0007, 1'b1, 1'b1, 1'b1);
        check_hilo("reset_div", 32'h0, 32'h0);

        clock_op(32'h0000_0064, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
        clock_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b1, 1'b0);
`ifdef EXEC_MULT_EN
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        clock_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 1'b0);
        check_hilo("div_over_mult", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`else
        check_hilo("mult_ignored", 32'h0000_0002, 32'h0000_000E);
        clock_op(32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b1, 1'b0);
        check_hilo("div_with_mult", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
